// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef logic [1:0] lane_sel_t;

    // Saturating increment: a counter parked at CNT_MAX stays there.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lane_reg_v1.sv
// One-entry valid/ready holding register: load wins over drain so a full lane
// can be refilled in the same cycle it empties.
module lane_reg_v1 #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [width-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [width-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [width-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mux4_v1.sv
// Plain 4-input selector; the demux reuses it at 1-bit width for the in_ready steer.
module mux4_v1 #(
    parameter int width = 32
) (
    input  logic [width-1:0] in0_i,
    input  logic [width-1:0] in1_i,
    input  logic [width-1:0] in2_i,
    input  logic [width-1:0] in3_i,
    input  logic [1:0]       sel_i,
    output logic [width-1:0] out_o
);

    always_comb begin
        out_o = in0_i;
        case (sel_i)
            2'd0:    out_o = in0_i;
            2'd1:    out_o = in1_i;
            2'd2:    out_o = in2_i;
            default: out_o = in3_i;
        endcase
    end

endmodule

// File: rtl/demux4_reg_v1.sv
// Registered 1-to-4 valid/ready stream demultiplexer with per-lane holding registers.
// Define DEMUX_PERF_CNT_EN to add saturating per-lane transfer counters (cnt0..cnt3).
module demux4_reg_v1
    import demux_pkg::*;
#(
    parameter int width = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [width-1:0]     in_data,
    input  lane_sel_t            in_sel,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [width-1:0]     out_data0,
    output logic [width-1:0]     out_data1,
    output logic [width-1:0]     out_data2,
    output logic [width-1:0]     out_data3
`ifdef DEMUX_PERF_CNT_EN
    ,output logic [CNT_W-1:0]    cnt0
    ,output logic [CNT_W-1:0]    cnt1
    ,output logic [CNT_W-1:0]    cnt2
    ,output logic [CNT_W-1:0]    cnt3
`endif
);

    logic [NUM_LANES-1:0] lane_free;
    logic [NUM_LANES-1:0] lane_load;
    logic                 accept;
    logic [width-1:0]     lane_data [NUM_LANES];

    // Only the addressed lane gates the input; other full lanes never stall it.
    assign lane_free = ~out_valid | out_ready;

    mux4_v1 #(.width(1)) u_rdy_mux (
        .in0_i (lane_free[0]),
        .in1_i (lane_free[1]),
        .in2_i (lane_free[2]),
        .in3_i (lane_free[3]),
        .sel_i (in_sel),
        .out_o (in_ready)
    );

    assign accept = in_valid & in_ready;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign lane_load[k] = accept && (in_sel == lane_sel_t'(k));

        lane_reg_v1 #(.width(width)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .load_i  (lane_load[k]),
            .data_i  (in_data),
            .ready_i (out_ready[k]),
            .valid_o (out_valid[k]),
            .data_o  (lane_data[k])
        );
    end

    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];

`ifdef DEMUX_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_LANES];
    logic [CNT_W-1:0] cnt_d [NUM_LANES];

    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            cnt_d[k] = cnt_q[k];
            if (out_valid[k] && out_ready[k]) begin
                cnt_d[k] = sat_inc(cnt_q[k]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_reg_v1.sv
// Self-checking bench for demux4_reg_v1: vector table, corner sequences, and a
// per-lane scoreboard that checks every output transfer against accepted beats.
module tb_demux4_reg_v1;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
`ifdef DEMUX_PERF_CNT_EN
    logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

    demux4_reg_v1 #(.width(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3)
`ifdef DEMUX_PERF_CNT_EN
        ,.cnt0     (cnt0)
        ,.cnt1     (cnt1)
        ,.cnt2     (cnt2)
        ,.cnt3     (cnt3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    // Reference model, advanced once per cycle on the falling edge
    logic [31:0] sb [4][$];
    logic [3:0]  mvalid;
    logic [3:0]  hold_prev;
    logic [31:0] hold_data [4];
    int          mcnt [4];

    always @(negedge clk) begin : mon
        logic exp_rdy;
        logic [31:0] exp_d;
        if (rst) begin
            mvalid    = '0;
            hold_prev = '0;
            for (int k = 0; k < 4; k++) begin
                sb[k].delete();
                mcnt[k] = 0;
            end
        end else begin
            chk("mon_out_valid", 64'(out_valid), 64'(mvalid));
            exp_rdy = !mvalid[in_sel] || out_ready[in_sel];
            chk("mon_in_ready", 64'(in_ready), 64'(exp_rdy));
            for (int k = 0; k < 4; k++) begin
                if (hold_prev[k] && out_valid[k])
                    chk("mon_hold_stable", 64'(od[k]), 64'(hold_data[k]));
                hold_prev[k] = mvalid[k] && !out_ready[k];
                hold_data[k] = od[k];
                if (mvalid[k] && out_ready[k]) begin
                    if (sb[k].size() == 0) begin
                        chk("mon_sb_underflow", 64'(k), 64'hFFFF);
                    end else begin
                        exp_d = sb[k].pop_front();
                        chk("mon_lane_data", 64'(od[k]), 64'(exp_d));
                    end
                    mvalid[k] = 1'b0;
                    if (mcnt[k] < 65535) mcnt[k]++;
                end
            end
            if (in_valid && exp_rdy) begin
                sb[in_sel].push_back(in_data);
                mvalid[in_sel] = 1'b1;
            end
        end
    end

    typedef struct {
        logic        vld;
        logic [1:0]  sel;
        logic [31:0] data;
        logic [3:0]  rdy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
    } vec_t;

    vec_t vecs [12];

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] r);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             vld   sel   data          rdy      in_rdy ov_after
        vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b1111, 1'b1, 4'b0100};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000};
        vecs[2]  = '{1'b1, 2'd1, 32'hA1,       4'b0000, 1'b1, 4'b0010};
        vecs[3]  = '{1'b1, 2'd1, 32'hA2,       4'b0000, 1'b0, 4'b0010};
        vecs[4]  = '{1'b1, 2'd3, 32'hA3,       4'b0000, 1'b1, 4'b1010};
        vecs[5]  = '{1'b1, 2'd3, 32'hA4,       4'b1000, 1'b1, 4'b1010};
        vecs[6]  = '{1'b1, 2'd0, 32'hA5,       4'b0000, 1'b1, 4'b1011};
        vecs[7]  = '{1'b1, 2'd2, 32'hA6,       4'b0000, 1'b1, 4'b1111};
        vecs[8]  = '{1'b1, 2'd3, 32'hA7,       4'b1111, 1'b1, 4'b1000};
        vecs[9]  = '{1'b0, 2'd1, 32'h0,        4'b0000, 1'b1, 4'b1000};
        vecs[10] = '{1'b1, 2'd3, 32'hA8,       4'b0000, 1'b0, 4'b1000};
        vecs[11] = '{1'b0, 2'd0, 32'h0,        4'b1111, 1'b1, 4'b0000};

        rst = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h1);
        chk("reset_out_data0", 64'(out_data0), 64'h0);
        chk("reset_out_data3", 64'(out_data3), 64'h0);
        step();
        step();
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].vld, vecs[i].sel, vecs[i].data, vecs[i].rdy);
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (i == 0) chk("steer_data2", 64'(out_data2), 64'hDEADBEEF);
            if (i == 8) chk("drainfill_data3", 64'(out_data3), 64'hA7);
            if (i == 5) chk("iso_lane1_data", 64'(out_data1), 64'hA1);
        end

        // Pass-through on a full lane 0 at one beat per cycle
        drive(1'b1, 2'd0, 32'h100, 4'b0000);
        step();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd0, 32'(i), 4'b1111);
            #1;
            chk($sformatf("pass%0d_in_ready", i), 64'(in_ready), 64'h1);
            @(posedge clk);
            #1;
            chk($sformatf("pass%0d_valid0", i), 64'(out_valid[0]), 64'h1);
            chk($sformatf("pass%0d_data0", i), 64'(out_data0), 64'(i));
        end
        drive(1'b0, 2'd0, 32'h0, 4'b1111);
        step();
        chk("pass_drained", 64'(out_valid), 64'h0);

`ifdef DEMUX_PERF_CNT_EN
        chk("cnt0_model", 64'(cnt0), 64'(mcnt[0]));
        chk("cnt1_model", 64'(cnt1), 64'(mcnt[1]));
        chk("cnt2_model", 64'(cnt2), 64'(mcnt[2]));
        chk("cnt3_model", 64'(cnt3), 64'(mcnt[3]));
`endif

        // Asynchronous reset with lanes 0 and 2 holding beats
        drive(1'b1, 2'd0, 32'hC0, 4'b0000);
        step();
        drive(1'b1, 2'd2, 32'hC2, 4'b0000);
        step();
        drive(1'b0, 2'd2, 32'h0, 4'b0000);
        #1;
        chk("prereset_out_valid", 64'(out_valid), 64'h5);
        #1;
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'h0);
        chk("midreset_in_ready", 64'(in_ready), 64'h1);
`ifdef DEMUX_PERF_CNT_EN
        chk("midreset_cnts", 64'({cnt0, cnt1, cnt2, cnt3}), 64'h0);
`endif
        step();
        step();
        rst = 1'b0;
        #1;
        chk("postreset_out_valid", 64'(out_valid), 64'h0);

`ifdef DEMUX_PERF_CNT_EN
        // Saturate lane 1 counter; lane 1 drains every cycle
        for (int i = 0; i < 65540; i++) begin
            drive(1'b1, 2'd1, 32'(i), 4'b0010);
            step();
        end
        drive(1'b0, 2'd0, 32'h0, 4'b0010);
        step();
        chk("sat_cnt1", 64'(cnt1), 64'hFFFF);
        chk("sat_cnt0", 64'(cnt0), 64'h0);
        chk("sat_cnt2", 64'(cnt2), 64'h0);
        chk("sat_cnt3", 64'(cnt3), 64'h0);
        chk("sat_cnt1_model", 64'(cnt1), 64'(mcnt[1]));
`endif

        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sb_empty%0d", k), 64'(sb[k].size()), 64'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
